pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard scheduler and stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside `forward_unit` and covers the hazards forwarding cannot resolve: load-use, branch-in-ID operand dependencies, multi-cycle mult/div occupancy and program halt. It drives the enable and flush controls of PC, IF/ID, ID/EX and EX/MEM. It also issues the start handshake to the mult/div unit.

## Interface
Parameters:
- `CNT_W`, 32, width of the stall-cycle counter (only used with `PIPELINE_CTRL_PERF_EN`).

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ID_rs`, `ID_rt`  in  5 each  source register numbers in ID.
- `ID_rs_used`, `ID_rt_used`  in  1 each  ID instruction actually reads rs / rt.
- `ID_branch`  in  1  ID instruction is a branch/jr that compares registers in ID.
- `ID_taken`  in  1  ID branch/jump resolves taken this cycle.
- `ID_halt`  in  1  ID instruction is a halt syscall.
- `EX_RW`  in  5  destination register in EX.
- `EX_regwe`  in  1  EX instruction writes a register.
- `EX_ramtoreg`  in  1  EX instruction is a load.
- `EX_md`  in  1  EX instruction is mult/div.
- `MEM_RW`  in  5  destination register in MEM.
- `MEM_ramtoreg`  in  1  MEM instruction is a load.
- `md_done`  in  1  mult/div unit result ready (one-cycle pulse).
- `resume`  in  1  leave halt.
- `md_start`  out  1  one-cycle start pulse to the mult/div unit.
- `PC_en`, `IFID_en`, `IDEX_en`, `EXMEM_en`  out  1 each  register write enables.
- `IFID_flush`, `IDEX_flush`  out  1 each  insert a bubble (synchronous clear) next edge.
- `halted`  out  1  controller is in HALT.
- `stall_cnt`  out  CNT_W  stalled-cycle count (only with `PIPELINE_CTRL_PERF_EN`).

## Operation
- FSM states: RUN, MD_BUSY, HALT. Outputs are combinational from state and inputs.
- Match condition: a register number is nonzero, equals the source, and the corresponding `_used` bit is set.
- `lu_stall`: `EX_ramtoreg & EX_regwe` and `EX_RW` matches rs or rt.
- `br_stall`: `ID_branch` and either of the following:
  - `EX_regwe` and `EX_RW` matches; or
  - `MEM_ramtoreg` and `MEM_RW` matches.
- `stall = lu_stall | br_stall`.
- Priority, highest first: MD freeze, then stall, then taken flush, then halt entry.
- RUN with `EX_md`:
  - `md_start=1`.
  - `PC_en=IFID_en=IDEX_en=EXMEM_en=0`.
  - Next state MD_BUSY.
- MD_BUSY:
  - All four enables stay 0 and `md_start=0`.
  - On `md_done=1`, all enables are 1 in that same cycle, and the next state is RUN.
- RUN with `stall` (and no MD freeze):
  - `PC_en=IFID_en=0`, `IDEX_flush=1`, `IDEX_en=EXMEM_en=1`.
  - `IFID_flush=0`: the branch outcome is ignored while stalled.
- RUN with no stall and `ID_taken`: `IFID_flush=1`.
- RUN with no stall, no MD freeze and `ID_halt`: the ID instruction advances normally, and the next state is HALT.
- HALT:
  - `PC_en=IFID_en=0`, `IDEX_flush=1`, `IDEX_en=EXMEM_en=1`, so the pipeline drains with bubbles.
  - `halted=1`.
  - `resume=1` gives next state RUN.
- Idle RUN: all enables are 1 and all flushes, `md_start` and `halted` are 0.

## Timing
- Reset: state RUN and `stall_cnt=0`. With inputs idle, outputs are `PC_en=IFID_en=IDEX_en=EXMEM_en=1` and all other outputs 0.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM and is then forwarded.
- A branch dependent on an EX ALU result stalls 1 cycle.
- A branch dependent on a load stalls 2 cycles: 1 cycle from the EX match, then 1 cycle from the MEM load match.
- `md_start` is high for exactly one cycle per mult/div instruction, including when `EX_md` is held through MD_BUSY.
- `md_done` in the same cycle as `md_start`: ignored. The FSM still enters MD_BUSY.
- `md_done` while in RUN or HALT: ignored.
- Reset asserted while in MD_BUSY or HALT: returns immediately to RUN. `md_start` is issued again only on a new RUN cycle with `EX_md`.
- `resume` in RUN: ignored.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - `stall_cnt` increments (and wraps) on every cycle with `PC_en=0`: MD freeze, stall, or HALT.
  - Reset clears it to 0.
- `PIPELINE_CTRL_PERF_EN` undefined: the `stall_cnt` port and its counter are absent.

## Test plan
- Load-use hazard:
  - Stimulus: `EX_ramtoreg=1, EX_regwe=1, EX_RW=8, ID_rs=8, ID_rs_used=1`, held for one cycle.
  - Response: that cycle `PC_en=0, IFID_en=0, IDEX_flush=1`; next cycle idle outputs.
  - Repeat with `EX_RW=0`: no stall.
- Branch after load:
  - Stimulus: `ID_branch=1, ID_rt=9`. Cycle 1: EX load to `$9`. Cycle 2: MEM load to `$9`.
  - Response: two consecutive stall cycles. `ID_taken=1` in those cycles gives `IFID_flush=0`.
  - Third cycle with `ID_taken=1`: `IFID_flush=1`.
- Mult/div:
  - Stimulus: `EX_md=1` held, `md_done` pulsed 5 cycles later.
  - Response: `md_start` high for 1 cycle only; all enables 0 for 5 cycles; enables 1 in the `md_done` cycle.
  - With `PIPELINE_CTRL_PERF_EN`: `stall_cnt=5`.
- Halt:
  - Stimulus: `ID_halt=1` for one cycle, then `resume=1` after 4 cycles.
  - Response: `halted=1` with `PC_en=0, IDEX_flush=1` for 4 cycles; RUN outputs on the cycle after `resume`.
- Reset mid-MD_BUSY:
  - Stimulus: assert `rst` asynchronously two cycles into MD_BUSY.
  - Response: outputs immediately show RUN values, `stall_cnt=0`, and no spurious `md_start` after release while `EX_md=0`.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard-information and pipeline-control bundle between the MIPS datapath and pipeline_ctrl.
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_rs_used;
  logic       ID_rt_used;
  logic       ID_branch;
  logic       ID_taken;
  logic       ID_halt;
  logic [4:0] EX_RW;
  logic       EX_regwe;
  logic       EX_ramtoreg;
  logic       EX_md;
  logic [4:0] MEM_RW;
  logic       MEM_ramtoreg;
  logic       md_done;
  logic       resume;
  logic       md_start;
  logic       PC_en;
  logic       IFID_en;
  logic       IDEX_en;
  logic       EXMEM_en;
  logic       IFID_flush;
  logic       IDEX_flush;
  logic       halted;

  modport master (
    output ID_rs, ID_rt, ID_rs_used, ID_rt_used, ID_branch, ID_taken, ID_halt,
           EX_RW, EX_regwe, EX_ramtoreg, EX_md, MEM_RW, MEM_ramtoreg, md_done, resume,
    input  md_start, PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, halted
  );

  modport slave (
    input  ID_rs, ID_rt, ID_rs_used, ID_rt_used, ID_branch, ID_taken, ID_halt,
           EX_RW, EX_regwe, EX_ramtoreg, EX_md, MEM_RW, MEM_ramtoreg, md_done, resume,
    output md_start, PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, halted
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard scheduler and stall/flush sequencer for the 5-stage MIPS pipeline.
// Optional stalled-cycle counter enabled by defining PIPELINE_CTRL_PERF_EN.
//
// state   | meaning
// RUN     | normal issue; detects stalls, taken flushes, halt entry, mult/div start
// MD_BUSY | pipeline frozen until the mult/div unit pulses md_done
// HALT    | fetch frozen, bubbles drain the back end until resume
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;

  state_t state, state_nxt;

  logic ex_hit, mem_hit, lu_stall, br_stall, stall;
  logic md_start, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, halted;

  function automatic logic reg_match(input logic [4:0] rw, input logic [4:0] src,
                                     input logic used);
    return (rw != 5'd0) && (rw == src) && used;
  endfunction

  always_comb begin
    ex_hit   = reg_match(bus.EX_RW, bus.ID_rs, bus.ID_rs_used)
             | reg_match(bus.EX_RW, bus.ID_rt, bus.ID_rt_used);
    mem_hit  = reg_match(bus.MEM_RW, bus.ID_rs, bus.ID_rs_used)
             | reg_match(bus.MEM_RW, bus.ID_rt, bus.ID_rt_used);
    lu_stall = bus.EX_ramtoreg & bus.EX_regwe & ex_hit;
    br_stall = bus.ID_branch & ((bus.EX_regwe & ex_hit) | (bus.MEM_ramtoreg & mem_hit));
    stall    = lu_stall | br_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    md_start   = 1'b0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        if (bus.EX_md) begin
          md_start  = 1'b1;
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          state_nxt = MD_BUSY;
        end else if (stall) begin
          // Branch outcome is discarded while stalled; it re-resolves once operands are ready.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (bus.ID_taken) begin
          ifid_flush = 1'b1;
        end else if (bus.ID_halt) begin
          state_nxt = HALT;
        end
      end
      MD_BUSY: begin
        if (bus.md_done) begin
          state_nxt = RUN;
        end else begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
        end
      end
      HALT: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        halted     = 1'b1;
        if (bus.resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.md_start   = md_start;
  assign bus.PC_en      = pc_en;
  assign bus.IFID_en    = ifid_en;
  assign bus.IDEX_en    = idex_en;
  assign bus.EXMEM_en   = exmem_en;
  assign bus.IFID_flush = ifid_flush;
  assign bus.IDEX_flush = idex_flush;
  assign bus.halted     = halted;

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        stall_cnt <= '0;
    else if (!pc_en) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; stall counter checks active with PIPELINE_CTRL_PERF_EN.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  // {md_start, PC_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, halted}
  localparam logic [7:0] O_IDLE   = 8'h78;
  localparam logic [7:0] O_STALL  = 8'h1A;
  localparam logic [7:0] O_MDSTRT = 8'h80;
  localparam logic [7:0] O_FREEZE = 8'h00;
  localparam logic [7:0] O_TAKEN  = 8'h7C;
  localparam logic [7:0] O_HALT   = 8'h1B;

  pipeline_ctrl_if bus ();

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  pipeline_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
  pipeline_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {bus.md_start, bus.PC_en, bus.IFID_en, bus.IDEX_en, bus.EXMEM_en,
                bus.IFID_flush, bus.IDEX_flush, bus.halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic clr();
    bus.ID_rs = 5'd0;  bus.ID_rt = 5'd0;  bus.ID_rs_used = 1'b0; bus.ID_rt_used = 1'b0;
    bus.ID_branch = 1'b0; bus.ID_taken = 1'b0; bus.ID_halt = 1'b0;
    bus.EX_RW = 5'd0; bus.EX_regwe = 1'b0; bus.EX_ramtoreg = 1'b0; bus.EX_md = 1'b0;
    bus.MEM_RW = 5'd0; bus.MEM_ramtoreg = 1'b0; bus.md_done = 1'b0; bus.resume = 1'b0;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    #1;
    chk("reset_outputs", {24'd0, obs}, {24'd0, O_IDLE});
`ifdef PIPELINE_CTRL_PERF_EN
    chk("reset_cnt", stall_cnt, 32'd0);
`endif
    #11 rst = 1'b0;
    cyc();

    // load-use on rs
    bus.EX_ramtoreg = 1'b1; bus.EX_regwe = 1'b1; bus.EX_RW = 5'd8;
    bus.ID_rs = 5'd8; bus.ID_rs_used = 1'b1;
    #1 chk("lu_rs", {24'd0, obs}, {24'd0, O_STALL});
    cyc(); clr();
    #1 chk("lu_after", {24'd0, obs}, {24'd0, O_IDLE});
    // load-use on rt
    bus.EX_ramtoreg = 1'b1; bus.EX_regwe = 1'b1; bus.EX_RW = 5'd8;
    bus.ID_rt = 5'd8; bus.ID_rt_used = 1'b1;
    #1 chk("lu_rt", {24'd0, obs}, {24'd0, O_STALL});
    cyc();
    bus.ID_rt_used = 1'b0;
    #1 chk("lu_rt_unused", {24'd0, obs}, {24'd0, O_IDLE});
    cyc(); clr();
    // $0 never stalls
    bus.EX_ramtoreg = 1'b1; bus.EX_regwe = 1'b1; bus.EX_RW = 5'd0;
    bus.ID_rs = 5'd0; bus.ID_rs_used = 1'b1;
    #1 chk("lu_zero_reg", {24'd0, obs}, {24'd0, O_IDLE});
    cyc(); clr();

    // branch depending on EX ALU result: one stall
    bus.ID_branch = 1'b1; bus.ID_rs = 5'd3; bus.ID_rs_used = 1'b1; bus.ID_taken = 1'b1;
    bus.EX_regwe = 1'b1; bus.EX_RW = 5'd3;
    #1 chk("br_alu_stall", {24'd0, obs}, {24'd0, O_STALL});
    cyc();
    bus.EX_regwe = 1'b0; bus.EX_RW = 5'd0; bus.MEM_RW = 5'd3;
    #1 chk("br_alu_taken", {24'd0, obs}, {24'd0, O_TAKEN});
    cyc(); clr();

    // branch depending on a load: two stalls, then taken flush
    bus.ID_branch = 1'b1; bus.ID_rt = 5'd9; bus.ID_rt_used = 1'b1; bus.ID_taken = 1'b1;
    bus.EX_ramtoreg = 1'b1; bus.EX_regwe = 1'b1; bus.EX_RW = 5'd9;
    #1 chk("br_ld_ex", {24'd0, obs}, {24'd0, O_STALL});
    cyc();
    bus.EX_ramtoreg = 1'b0; bus.EX_regwe = 1'b0; bus.EX_RW = 5'd0;
    bus.MEM_ramtoreg = 1'b1; bus.MEM_RW = 5'd9;
    #1 chk("br_ld_mem", {24'd0, obs}, {24'd0, O_STALL});
    cyc();
    bus.MEM_ramtoreg = 1'b0; bus.MEM_RW = 5'd0;
    #1 chk("br_ld_taken", {24'd0, obs}, {24'd0, O_TAKEN});
    cyc(); clr();

    // md_done in RUN is ignored
    bus.md_done = 1'b1;
    #1 chk("md_done_run", {24'd0, obs}, {24'd0, O_IDLE});
    cyc(); clr();

    // mult/div with EX_md held, md_done 5 cycles later
    bus.EX_md = 1'b1;
    #1 chk("md_start", {24'd0, obs}, {24'd0, O_MDSTRT});
    for (int i = 1; i < 5; i++) begin
      cyc();
      #1 chk($sformatf("md_busy_%0d", i), {24'd0, obs}, {24'd0, O_FREEZE});
    end
    cyc();
    bus.md_done = 1'b1;
    #1 chk("md_done_cycle", {24'd0, obs}, {24'd0, O_IDLE});
    cyc(); clr();
    #1 chk("md_after", {24'd0, obs}, {24'd0, O_IDLE});
`ifdef PIPELINE_CTRL_PERF_EN
    chk("cnt_after_md", stall_cnt, 32'd10);
`endif

    // md_done coincident with md_start is ignored
    bus.EX_md = 1'b1; bus.md_done = 1'b1;
    #1 chk("md_same_start", {24'd0, obs}, {24'd0, O_MDSTRT});
    cyc(); clr();
    #1 chk("md_same_busy", {24'd0, obs}, {24'd0, O_FREEZE});
    cyc();
    bus.md_done = 1'b1;
    #1 chk("md_same_done", {24'd0, obs}, {24'd0, O_IDLE});
    cyc(); clr();

    // halt for 4 cycles, md_done ignored in HALT, resume on the 4th
    bus.ID_halt = 1'b1;
    #1 chk("halt_entry", {24'd0, obs}, {24'd0, O_IDLE});
    for (int i = 1; i <= 4; i++) begin
      cyc(); clr();
      if (i == 2) bus.md_done = 1'b1;
      if (i == 4) bus.resume = 1'b1;
      #1 chk($sformatf("halt_%0d", i), {24'd0, obs}, {24'd0, O_HALT});
    end
    cyc(); clr();
    #1 chk("halt_resumed", {24'd0, obs}, {24'd0, O_IDLE});
`ifdef PIPELINE_CTRL_PERF_EN
    chk("cnt_after_halt", stall_cnt, 32'd16);
`endif
    // resume in RUN is ignored
    bus.resume = 1'b1;
    cyc(); clr();
    #1 chk("resume_run", {24'd0, obs}, {24'd0, O_IDLE});

    // asynchronous reset two cycles into MD_BUSY
    bus.EX_md = 1'b1;
    #1 chk("rst_md_start", {24'd0, obs}, {24'd0, O_MDSTRT});
    cyc(); clr();
    cyc();
    #1 chk("rst_md_busy", {24'd0, obs}, {24'd0, O_FREEZE});
    #2 rst = 1'b1;
    #1 chk("rst_async_run", {24'd0, obs}, {24'd0, O_IDLE});
`ifdef PIPELINE_CTRL_PERF_EN
    chk("rst_async_cnt", stall_cnt, 32'd0);
`endif
    #1 rst = 1'b0;
    cyc();
    #1 chk("rst_no_md_start", {24'd0, obs}, {24'd0, O_IDLE});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
